uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  - 8N1 serial transmitter with a small write FIFO; drives the UART Tx line from bytes written by the CPU/bus side.
//  - Mirror of the UART receive path: produces exactly the frame format the receiver samples (LSB first, idle high).
//  - Sits between the memory-mapped UART write port (w_data/we) and the Tx pin.
// PARAMETERS
//  - CLKS_PER_BIT  40  clock cycles per serial bit (baud divisor); legal range >= 2
//  - FIFO_DEPTH     4  byte entries in the write FIFO; power of two, >= 2
//  - STOP_BITS      1  stop bits per frame; 1 or 2
// PORTS
//  - clk       in   1  system clock, all state on rising edge
//  - reset     in   1  asynchronous, active-high reset
//  - w_data    in   8  byte to transmit
//  - we        in   1  write strobe; one byte enqueued per cycle with we=1 and full=0
//  - Tx        out  1  serial output, idle high
//  - full      out  1  FIFO holds FIFO_DEPTH bytes
//  - tx_empty  out  1  FIFO holds 0 bytes
//  - busy      out  1  FSM not in IDLE (frame on the line)
// BEHAVIOUR
//  - Reset (async): Tx=1, full=0, tx_empty=1, busy=0, FIFO pointers/count=0, FSM=IDLE, baud/bit counters=0.
//  - FSM states: IDLE, START, DATA, [PARITY], STOP. Tx is registered: START->0, DATA->shift[0], STOP->1, IDLE->1.
//  - IDLE: if FIFO non-empty, pop head into shift reg, go START, baud_cnt=0. Write at edge N -> pop at N+1 -> Tx=0 from N+2.
//  - Each non-IDLE state lasts exactly CLKS_PER_BIT cycles; baud_cnt counts 0..CLKS_PER_BIT-1, state advances on terminal count.
//  - DATA: 8 bits LSB first; shift right each bit period; bit_cnt 0..7, leaves DATA after bit_cnt=7 terminal.
//  - STOP: STOP_BITS*CLKS_PER_BIT cycles of Tx=1; then IDLE, or straight to START with next pop if FIFO non-empty (back-to-back frames, no idle gap).
//  - Frame length without parity: (9+STOP_BITS)*CLKS_PER_BIT cycles; 400 cycles at defaults.
//  - FIFO: count width $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
//  - we while full=1: byte dropped, no pointer/count change, even if a pop occurs the same cycle.
//  - we and pop same cycle, not full: both happen, count unchanged.
//  - full/tx_empty/busy are registered flags updated on the same edge as count/state.
//  - w_data sampled only on the we edge; changes while a frame is on the line do not affect it.
//  - Reset mid-frame: Tx forced to 1 immediately, partial frame abandoned, queued bytes discarded.
// CONFIGURATION
//  - Macro UART_TX_PARITY_EN.
//  - Defined: PARITY state after DATA, one bit period carrying even parity (XOR of the 8 data bits); frame +1 bit.
//  - Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.
// STRUCTURE
//  - Shared header uart_defs.vh: FSM state encodings (IDLE/START/DATA/PARITY/STOP), UART_DATA_W=8, default CLKS_PER_BIT=40.
//  - The receiver includes the same header so frame constants match on both ends.
//  - One sub-module: uart_sync_fifo (param WIDTH, DEPTH; ports clk, reset, push, din, pop, dout, full, empty).
//  - Baud counter, bit counter, shift register and FSM live in uart_tx_fifo.
// TESTING
//  - Reset idle: assert reset mid-run, hold 3 cycles -> Tx=1, tx_empty=1, full=0, busy=0 throughout.
//  - Single byte: write 8'h08 -> Tx low 40 cycles, then 0,0,0,1,0,0,0,0 at 40 cycles each, then stop high; busy drops 400 cycles after start.
//  - Back-to-back: write 8'h07 then 8'h2A on consecutive cycles -> two 400-cycle frames with no idle gap; tx_empty=1 once second is popped.
//  - Overflow: 6 writes 8'h01,8'h09,8'h00,8'h08,8'hFF,8'hEE in 6 cycles -> 8'h01 popped into frame; 8'h09,8'h00,8'h08,8'hFF fill FIFO; 8'hEE dropped; 5 frames.
//  - Reset mid-frame: reset during DATA bit 3 of 8'h55 -> Tx=1 immediately, FIFO empty, next write of 8'h03 sends a clean frame.
//  - Parity (UART_TX_PARITY_EN): write 8'h07 -> parity bit 1, frame 440 cycles; 8'h03 -> parity 0.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: frame constants, FSM state encodings and byte type shared
// by the UART transmit path (and, on the other end, the receiver).
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state and an
// even-parity helper).
package uart_tx_fifo_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int DEF_CLKS_PER_BIT = 40;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    // Encodings are fixed so the receiver can reuse the same values.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_e;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input uart_byte_t b);
        return ^b;
    endfunction
`endif

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write-port bundle between the memory-mapped bus side and
// the UART transmitter.
//   w_data   byte to transmit            (master -> slave)
//   we       write strobe                (master -> slave)
//   full     write FIFO full             (slave -> master)
//   tx_empty write FIFO empty            (slave -> master)
//   busy     frame currently on the line (slave -> master)
interface uart_tx_fifo_if;
    import uart_tx_fifo_pkg::*;

    uart_byte_t w_data;
    logic       we;
    logic       full;
    logic       tx_empty;
    logic       busy;

    modport master (output w_data, output we, input full, input tx_empty, input busy);
    modport slave  (input w_data, input we, output full, output tx_empty, output busy);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with first-word-fall-through read and
// registered full/empty flags.
//   clk, reset  clock, asynchronous active-high reset
//   push, din   enqueue din when push=1 and full=0
//   pop, dout   dout shows the head entry; pop=1 and empty=0 dequeues it
//   full, empty registered occupancy flags, updated with the count
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, count_nxt;
    logic             do_push, do_pop;

    // A push while full is dropped even if a pop frees a slot the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small write FIFO.
//   clk, reset  clock, asynchronous active-high reset
//   bus         uart_tx_fifo_if.slave: w_data/we in, full/tx_empty/busy out
//   Tx          registered serial output, idle high, LSB first
// Optional feature macro: UART_TX_PARITY_EN inserts one even-parity bit
// between the data bits and the stop bit(s).
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus,
    output logic          Tx
);
    localparam int BW = $clog2(CLKS_PER_BIT);

    tx_state_e     state, state_nxt;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    uart_byte_t    shift;
    uart_byte_t    fifo_dout;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          baud_tc;
    logic          stop_last;
    logic          tx_nxt;
`ifdef UART_TX_PARITY_EN
    logic          par;
`endif

    uart_sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.we),
        .din   (bus.w_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (bus.full),
        .empty (fifo_empty)
    );

    assign bus.tx_empty = fifo_empty;
    assign baud_tc      = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    // bit_cnt doubles as the stop-bit counter while in STOP.
    assign stop_last    = (bit_cnt == 3'(STOP_BITS - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!fifo_empty) state_nxt = ST_START;
            ST_START: if (baud_tc) state_nxt = ST_DATA;
            ST_DATA: begin
                if (baud_tc && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (baud_tc) state_nxt = ST_STOP;
`endif
            ST_STOP: begin
                // Chain straight into the next frame when a byte is waiting.
                if (baud_tc && stop_last) state_nxt = fifo_empty ? ST_IDLE : ST_START;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: line level for the next cycle and FIFO pop
    always_comb begin
        tx_nxt   = 1'b1;
        fifo_pop = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_nxt   = 1'b1;
                fifo_pop = !fifo_empty;
            end
            ST_START: tx_nxt = 1'b0;
            ST_DATA:  tx_nxt = shift[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_nxt = par;
`endif
            ST_STOP: begin
                tx_nxt   = 1'b1;
                fifo_pop = baud_tc && stop_last && !fifo_empty;
            end
            default: tx_nxt = 1'b1;
        endcase
    end

    // Datapath: counters, shift register, registered line and busy flag.
    // Tx follows the state by one cycle, so every bit still lasts exactly
    // CLKS_PER_BIT cycles on the pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            Tx       <= 1'b1;
            bus.busy <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            Tx       <= tx_nxt;
            bus.busy <= (state_nxt != ST_IDLE);
            if (fifo_pop) begin
                shift    <= fifo_dout;
                baud_cnt <= '0;
                bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
                par      <= even_parity(fifo_dout);
`endif
            end else if (state != ST_IDLE) begin
                if (baud_tc) begin
                    baud_cnt <= '0;
                    bit_cnt  <= (state_nxt != state) ? 3'd0 : bit_cnt + 3'd1;
                    if (state == ST_DATA) shift <= shift >> 1;
                end else begin
                    baud_cnt <= baud_cnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
    localparam int CLKS  = 40;
    localparam int DEPTH = 4;
    localparam int STOPB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PBIT = 1;
`else
    localparam int PBIT = 0;
`endif
    localparam int FRAME = (9 + PBIT + STOPB) * CLKS;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx;
    int   checks = 0;
    int   failures = 0;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(.CLKS_PER_BIT(CLKS), .FIFO_DEPTH(DEPTH), .STOP_BITS(STOPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .Tx    (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: byte queue bounded by DEPTH, one frame at a time on the
    // line. A byte leaves the queue on the first edge at which the line is
    // free; the pin then carries bit k of the frame FRAME cycles long.
    logic [7:0] mq[$];
    int   ecnt = 0, free_at = 0;
    bit   cur_v = 0, prev_v = 0;
    int   cur_p, prev_p;
    logic [7:0] cur_b, prev_b;

    function automatic logic frame_bit(input int k, input logic [7:0] b);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PBIT == 1 && k == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic logic exp_tx();
        logic v = 1'b1;
        if (prev_v && ecnt > prev_p && ecnt <= prev_p + FRAME) v = frame_bit((ecnt - prev_p - 1) / CLKS, prev_b);
        if (cur_v && ecnt > cur_p && ecnt <= cur_p + FRAME) v = frame_bit((ecnt - cur_p - 1) / CLKS, cur_b);
        return v;
    endfunction

    initial begin
        logic we_s, push_ok;
        logic [7:0] wd_s;
        forever begin
            @(posedge clk);
            we_s = bus.we;
            wd_s = bus.w_data;
            if (reset) begin
                mq.delete();
                free_at = 0;
                cur_v = 0;
                prev_v = 0;
            end else begin
                ecnt++;
                push_ok = we_s && (mq.size() < DEPTH);
                if (ecnt >= free_at && mq.size() > 0) begin
                    prev_v = cur_v; prev_p = cur_p; prev_b = cur_b;
                    cur_v = 1; cur_p = ecnt; cur_b = mq.pop_front();
                    free_at = ecnt + FRAME;
                end
                if (push_ok) mq.push_back(wd_s);
            end
            #1;
            chk("m_tx", tx, exp_tx());
            chk("m_empty", bus.tx_empty, mq.size() == 0);
            chk("m_full", bus.full, mq.size() == DEPTH);
            chk("m_busy", bus.busy, !reset && free_at > ecnt);
        end
    end

    task automatic drive(input logic [7:0] b);
        @(negedge clk);
        bus.w_data = b;
        bus.we = 1'b1;
    endtask

    task automatic idle_bus();
        @(negedge clk);
        bus.we = 1'b0;
        bus.w_data = 8'($urandom);
    endtask

    task automatic wr(input logic [7:0] b);
        drive(b);
        idle_bus();
    endtask

    // Line decoder: waits for a start bit, samples mid-bit.
    task automatic rx_frame(input string tag, input logic [7:0] exp_b);
        int n = 0;
        logic [7:0] b;
        while (tx !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
        chk({tag, "_start_seen"}, n < 3000, 1);
        repeat (CLKS / 2 - 1) @(negedge clk);
        chk({tag, "_startbit"}, tx, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (CLKS) @(negedge clk);
            b[i] = tx;
        end
        chk({tag, "_data"}, b, exp_b);
        if (PBIT == 1) begin
            repeat (CLKS) @(negedge clk);
            chk({tag, "_parity"}, tx, ^exp_b);
        end
        repeat (CLKS) @(negedge clk);
        chk({tag, "_stopbit"}, tx, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(bus.tx_empty === 1'b1 && bus.busy === 1'b0) && n < 5000) begin @(negedge clk); n++; end
        chk({tag, "_idle_to"}, n < 5000, 1);
        repeat (5) @(negedge clk);
    endtask

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog t=%0t", $time);
        failures++;
        summary();
        $finish;
    end

    initial begin
        int n;
        bus.we = 1'b0;
        bus.w_data = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Reset while idle, held 3 cycles
        reset = 1'b1;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_empty", bus.tx_empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Single byte
        wr(8'h08);
        rx_frame("single", 8'h08);
        wait_idle("single");

        // Busy length of one frame
        wr(8'h08);
        n = 0;
        while (bus.busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (bus.busy === 1'b1 && n < 2000) begin @(negedge clk); n++; end
        chk("busy_len", n, FRAME);
        wait_idle("busylen");

        // Back-to-back
        drive(8'h07);
        drive(8'h2A);
        idle_bus();
        rx_frame("b2b0", 8'h07);
        rx_frame("b2b1", 8'h2A);
        wait_idle("b2b");

        // Overflow: six writes in six cycles, the last one is dropped
        drive(8'h01); drive(8'h09); drive(8'h00);
        drive(8'h08); drive(8'hFF); drive(8'hEE);
        idle_bus();
        chk("ovf_full", bus.full, 1);
        rx_frame("ovf0", 8'h01);
        rx_frame("ovf1", 8'h09);
        rx_frame("ovf2", 8'h00);
        rx_frame("ovf3", 8'h08);
        rx_frame("ovf4", 8'hFF);
        repeat (FRAME) @(negedge clk);
        chk("ovf_nosixth", bus.busy, 0);
        chk("ovf_empty", bus.tx_empty, 1);

        // Reset in the middle of data bit 3 of 8'h55 with a byte still queued
        drive(8'h55);
        drive(8'hAA);
        idle_bus();
        n = 0;
        while (tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        repeat (CLKS * 4 + CLKS / 2) @(negedge clk);
        chk("mid_pre_tx", tx, 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_empty", bus.tx_empty, 1);
        chk("mid_rst_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        wr(8'h03);
        rx_frame("after_rst", 8'h03);
        wait_idle("after_rst");

        // Parity values (checked inside rx_frame when enabled)
        wr(8'h07);
        rx_frame("par07", 8'h07);
        wait_idle("par07");
        wr(8'h03);
        rx_frame("par03", 8'h03);
        wait_idle("par03");

        // Random traffic against the model, including writes while full
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.we = ($urandom_range(0, 99) < 3);
            bus.w_data = 8'($urandom);
        end
        idle_bus();
        wait_idle("rand");

        summary();
        $finish;
    end
endmodule
